// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default frame width for the serial receiver
package serial_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;
    localparam int DEF_DATA_W = 4;
endpackage

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: parallel valid/ready word port with error flags and overrun pulse
interface serial_frame_rx_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] p_dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    modport master (output p_dout, dout_valid, parity_err, frame_err, overrun, input dout_ready);
    modport slave  (input p_dout, dout_valid, parity_err, frame_err, overrun, output dout_ready);
endinterface

// File: rtl/rx_out_buf.sv
// rx_out_buf: one-word valid/ready holding register that drops new words when full
module rx_out_buf
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              perr_i,
    input  logic              ferr_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              overrun_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic              take;
    // Load when empty or draining this cycle; otherwise the new word is lost and flagged
    always_comb begin
        take    = load_i & (~valid_q | ready_i);
        data_d  = take ? data_i : data_q;
        perr_d  = take ? perr_i : perr_q;
        ferr_d  = take ? ferr_i : ferr_q;
        valid_d = take | (valid_q & ~ready_i);
        ovr_d   = load_i & ~take;
    end
    // Holding register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign overrun_o = ovr_q;
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobed start/data/parity/stop frame receiver with buffered parallel output
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en_i,
    input  logic              s_din_i,
    serial_frame_rx_if.master out_if
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              perr_q, perr_d;
    logic              done, ferr, last_bit;
    // Frame state register and bit datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end
    // Next state: advance one step per strobe, LSB-first shift into the top of shreg
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        perr_d   = perr_q;
        last_bit = (cnt_q == CNT_W'(DATA_W - 1));
        if (bit_en_i) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = s_din_i ? ST_IDLE : ST_DATA;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                end
                ST_DATA: begin
                    shreg_d = DATA_W'({s_din_i, shreg_q} >> 1);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = !last_bit ? ST_DATA : (PARITY_EN ? ST_PARITY : ST_STOP);
                end
                ST_PARITY: begin
                    perr_d  = s_din_i ^ (^shreg_q);
                    state_d = ST_STOP;
                end
                ST_STOP: state_d = ST_IDLE;
            endcase
        end
    end
    // Outputs: frame completes on the stop-bit strobe, stop bit low means framing error
    always_comb begin
        done = bit_en_i && (state_q == ST_STOP);
        ferr = ~s_din_i;
    end
    rx_out_buf #(.DATA_W(DATA_W)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (done),
        .data_i   (shreg_q),
        .perr_i   (perr_q & PARITY_EN),
        .ferr_i   (ferr),
        .ready_i  (out_if.dout_ready),
        .data_o   (out_if.p_dout),
        .valid_o  (out_if.dout_valid),
        .perr_o   (out_if.parity_err),
        .ferr_o   (out_if.frame_err),
        .overrun_o(out_if.overrun)
    );
endmodule
